pipe_mult_fu: RTL and testbench

PIPE_MULT_FU -- requirements
Module: pipe_mult_fu

---
 rtl/pipe_mult_fu.sv | 155 +++++++++++++++
 tb/tb_pipe_mult_fu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult_fu.sv
// Elastic pipelined multiplier: each stage folds a fixed slice of multiplier bits
// into a 2*XLEN accumulator; completion is in issue order under backpressure and squash.
module pipe_mult_fu #(
  parameter int NUM_STAGES = 4,
  parameter int XLEN       = 32,
  parameter int ROBN_W     = 5,
  parameter int PRN_W      = 6,
  localparam int CNT_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [1:0]        func,
  input  logic [ROBN_W-1:0] robn,
  input  logic [PRN_W-1:0]  dest_prn,
  input  logic              avail,
  input  logic              squash,
  output logic              ready,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ROBN_W-1:0] output_robn,
  output logic [PRN_W-1:0]  output_dest_prn,
  output logic [CNT_W-1:0]  busy_count
);

  localparam int unsigned N  = NUM_STAGES;
  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned B  = W2 / NUM_STAGES;

  typedef enum logic [1:0] {
    F_MUL    = 2'b00,
    F_MULH   = 2'b01,
    F_MULHSU = 2'b10,
    F_MULHU  = 2'b11
  } func_t;

  logic [N-1:0]      st_valid;
  logic [W2-1:0]     st_acc    [N];
  logic [W2-1:0]     st_mcand  [N];
  logic [W2-1:0]     st_mplier [N];
  func_t             st_func   [N];
  logic [ROBN_W-1:0] st_robn   [N];
  logic [PRN_W-1:0]  st_prn    [N];

  logic [W2-1:0]     nxt_acc    [N];
  logic [W2-1:0]     nxt_mcand  [N];
  logic [W2-1:0]     nxt_mplier [N];
  func_t             nxt_func   [N];
  logic [ROBN_W-1:0] nxt_robn   [N];
  logic [PRN_W-1:0]  nxt_prn    [N];

  logic [N-1:0]  move;
  logic [N-1:0]  load;
  logic [W2-1:0] ext1, ext2;
  func_t         in_func;

  function automatic logic [W2-1:0] partial(input logic [W2-1:0] mc, input logic [W2-1:0] mp);
    logic [W2-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < B; j++) begin
      if (mp[j]) s = s + (mc << j);
    end
    return s;
  endfunction

  // Advance decisions resolve from the last stage backwards; a local vector keeps the
  // chain inside one evaluation.
  always_comb begin
    logic [N-1:0] mv;
    mv = '0;
    mv[N-1] = st_valid[N-1] & avail;
    for (int unsigned k = 1; k < N; k++) begin
      mv[N-1-k] = st_valid[N-1-k] & (~st_valid[N-k] | mv[N-k]);
    end
    move  = mv;
    ready = (~st_valid[0] | mv[0]) & ~squash;
    load  = '0;
    load[0] = start & ready;
    for (int unsigned i = 1; i < N; i++) begin
      load[i] = mv[i-1];
    end
  end

  always_comb begin
    in_func = func_t'(func);
    ext1 = {{XLEN{((in_func == F_MULH) || (in_func == F_MULHSU)) & rs1[XLEN-1]}}, rs1};
    ext2 = {{XLEN{(in_func == F_MULH) & rs2[XLEN-1]}}, rs2};

    nxt_acc[0]    = partial(ext1, ext2);
    nxt_mcand[0]  = ext1 << B;
    nxt_mplier[0] = ext2 >> B;
    nxt_func[0]   = in_func;
    nxt_robn[0]   = robn;
    nxt_prn[0]    = dest_prn;
    for (int unsigned i = 1; i < N; i++) begin
      nxt_acc[i]    = st_acc[i-1] + partial(st_mcand[i-1], st_mplier[i-1]);
      nxt_mcand[i]  = st_mcand[i-1] << B;
      nxt_mplier[i] = st_mplier[i-1] >> B;
      nxt_func[i]   = st_func[i-1];
      nxt_robn[i]   = st_robn[i-1];
      nxt_prn[i]    = st_prn[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_valid <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        st_acc[i]    <= '0;
        st_mcand[i]  <= '0;
        st_mplier[i] <= '0;
        st_func[i]   <= F_MUL;
        st_robn[i]   <= '0;
        st_prn[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (squash)       st_valid[i] <= 1'b0;
        else if (load[i]) st_valid[i] <= 1'b1;
        else if (move[i]) st_valid[i] <= 1'b0;

        if (load[i] && !squash) begin
          st_acc[i]    <= nxt_acc[i];
          st_mcand[i]  <= nxt_mcand[i];
          st_mplier[i] <= nxt_mplier[i];
          st_func[i]   <= nxt_func[i];
          st_robn[i]   <= nxt_robn[i];
          st_prn[i]    <= nxt_prn[i];
        end
      end
    end
  end

  always_comb begin
    done            = st_valid[N-1];
    result          = '0;
    output_robn     = '0;
    output_dest_prn = '0;
    if (st_valid[N-1]) begin
      result          = (st_func[N-1] == F_MUL) ? st_acc[N-1][XLEN-1:0] : st_acc[N-1][W2-1:XLEN];
      output_robn     = st_robn[N-1];
      output_dest_prn = st_prn[N-1];
    end
  end

  always_comb begin
    busy_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      busy_count = busy_count + CNT_W'(st_valid[i]);
    end
  end

endmodule

// File: tb/tb_pipe_mult_fu.sv
// Bench for pipe_mult_fu: directed vector table, hand sequences for stall/bubble/squash/reset,
// and random traffic checked against an in-order queue model of the pipeline.
module tb_pipe_mult_fu;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset, start, avail, squash;
  logic [31:0] rs1, rs2, result;
  logic [1:0]  func;
  logic [4:0]  robn, output_robn;
  logic [5:0]  dest_prn, output_dest_prn;
  logic        ready, done;
  logic [2:0]  busy_count;

  pipe_mult_fu #(.NUM_STAGES(N), .XLEN(32), .ROBN_W(5), .PRN_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .rs1(rs1), .rs2(rs2), .func(func),
    .robn(robn), .dest_prn(dest_prn), .avail(avail), .squash(squash), .ready(ready),
    .done(done), .result(result), .output_robn(output_robn),
    .output_dest_prn(output_dest_prn), .busy_count(busy_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rb;
    logic [5:0]  pr;
    int          pos;
  } op_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [4:0]  rb;
    logic [5:0]  pr;
    logic [31:0] exp;
  } vec_t;

  op_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic       last_done, last_acc;
  logic [4:0] last_robn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    longint sa, ua, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    ua = longint'({32'd0, a});
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      2'b00:   begin p = ua * ub; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  // One cycle: drive at the falling edge, check against the model, then advance the model
  // for the coming rising edge.
  task automatic step(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                      input logic [4:0] rb, input logic [5:0] pr, input logic av, input logic sq);
    int np[$];
    logic rdy_m;
    @(negedge clock);
    start = s; rs1 = a; rs2 = b; func = f; robn = rb; dest_prn = pr; avail = av; squash = sq;
    #1;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) np.push_back((q[0].pos == N-1) ? (av ? N : N-1) : q[0].pos + 1);
      else np.push_back((q[i].pos + 1 < np[i-1] - 1) ? q[i].pos + 1 : np[i-1] - 1);
    end
    rdy_m = !sq && (q.size() == 0 || np[np.size()-1] > 0);
    chk("ready", ready, rdy_m);
    chk("busy_count", busy_count, q.size());
    last_done = (q.size() > 0 && q[0].pos == N-1);
    chk("done", done, last_done);
    if (last_done) begin
      chk("result", result, q[0].res);
      chk("robn", output_robn, q[0].rb);
      chk("prn", output_dest_prn, q[0].pr);
    end else begin
      chk("idle_outputs", {result, output_robn, output_dest_prn}, 0);
    end
    last_robn = output_robn;
    for (int i = 0; i < q.size(); i++) q[i].pos = np[i];
    if (q.size() > 0 && q[0].pos == N) void'(q.pop_front());
    last_acc = s && rdy_m;
    if (sq) q.delete();
    else if (last_acc) q.push_back('{res: ref_mul(a, b, f), rb: rb, pr: pr, pos: 0});
  endtask

  task automatic idle(input logic av);
    step(1'b0, 32'd0, 32'd0, 2'b00, 5'd0, 6'd0, av, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    step(1'b1, v.a, v.b, v.f, v.rb, v.pr, 1'b1, 1'b0);
    for (k = 1; k <= 20; k++) begin
      idle(1'b1);
      if (last_done) break;
    end
    chk("latency", k, N);
    chk("vec_result", result, v.exp);
    idle(1'b1);
  endtask

  vec_t vecs[10];
  logic [4:0] got[$];
  int pending, sq_hits;
  logic [31:0] a, b;
  logic [31:0] corner[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  initial begin
    vecs[0] = '{32'd7,        32'd6,        2'b00, 5'd3,  6'd9,  32'd42};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 5'd1,  6'd1,  32'h00000000};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 5'd2,  6'd2,  32'hFFFFFFFE};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 5'd4,  6'd3,  32'hFFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 5'd5,  6'd4,  32'h00000001};
    vecs[5] = '{32'h80000000, 32'h80000000, 2'b01, 5'd6,  6'd5,  32'h40000000};
    vecs[6] = '{32'h80000000, 32'd2,        2'b10, 5'd7,  6'd6,  32'hFFFFFFFF};
    vecs[7] = '{32'h12345678, 32'h10,       2'b00, 5'd8,  6'd7,  32'h23456780};
    vecs[8] = '{32'h80000000, 32'd4,        2'b11, 5'd9,  6'd8,  32'h00000002};
    vecs[9] = '{32'd5,        32'd5,        2'b00, 5'd10, 6'd10, 32'd25};

    reset = 1'b1; start = 1'b0; avail = 1'b0; squash = 1'b0;
    rs1 = '0; rs2 = '0; func = '0; robn = '0; dest_prn = '0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {done, result, output_robn, output_dest_prn, busy_count}, 0);
    reset = 1'b0;
    idle(1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: fill, stall, then drain with the late issues queued behind.
    for (int k = 0; k < 6; k++) step(1'b1, $urandom, $urandom, 2'(k), 5'(k), 6'(k), 1'b0, 1'b0);
    chk("full_busy", busy_count, 4);
    chk("full_ready", ready, 0);
    pending = 4;
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      step(pending < 6, $urandom, $urandom, 2'b00, 5'(pending), 6'(pending), 1'b1, 1'b0);
      if (last_acc) pending++;
      if (last_done) got.push_back(last_robn);
      else if (got.size() > 0 && got.size() < 4) chk("drain_consecutive", got.size(), 4);
    end
    chk("drain_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) chk("drain_order", got[k], k);
    idle(1'b1);

    // Bubble collapse behind a held last stage.
    step(1'b1, 32'd3, 32'd4, 2'b00, 5'd20, 6'd20, 1'b0, 1'b0);
    idle(1'b0); idle(1'b0);
    step(1'b1, 32'd9, 32'd9, 2'b00, 5'd21, 6'd21, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    chk("bubble_busy", busy_count, 2);
    idle(1'b1);
    chk("bubble_a", {last_done, last_robn}, {1'b1, 5'd20});
    idle(1'b1);
    chk("bubble_b", {last_done, last_robn}, {1'b1, 5'd21});
    idle(1'b1);

    // Squash with a simultaneous start.
    for (int k = 0; k < 3; k++) step(1'b1, $urandom, $urandom, 2'b00, 5'(12 + k), 6'd0, 1'b0, 1'b0);
    step(1'b1, 32'd1, 32'd1, 2'b00, 5'd15, 6'd0, 1'b0, 1'b1);
    sq_hits = 0;
    for (int c = 0; c < 10; c++) begin
      idle(1'b1);
      if (last_done && last_robn >= 5'd12 && last_robn <= 5'd15) sq_hits++;
    end
    chk("squash_no_result", sq_hits, 0);

    // Asynchronous reset between edges with two operations in flight.
    step(1'b1, 32'd2, 32'd3, 2'b00, 5'd1, 6'd1, 1'b0, 1'b0);
    step(1'b1, 32'd4, 32'd5, 2'b00, 5'd2, 6'd2, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    chk("pre_reset_busy", busy_count, 2);
    reset = 1'b1;
    #1;
    chk("async_reset", {done, busy_count}, 0);
    q.delete();
    @(negedge clock);
    start = 1'b0; squash = 1'b0;
    reset = 1'b0;
    #1;
    chk("ready_after_reset", ready, 1);
    run_vec(vecs[9]);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      step($urandom_range(0, 9) < 6, a, b, 2'($urandom), 5'($urandom), 6'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    repeat (8) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
